// File: rtl/wptr_full.sv
// Write-side pointer/full logic for an async FIFO: Gray write pointer, registered full/almost-full, sticky overflow.
// Pointer and flags update 1 clk after an accepted write; writes while full are dropped. Optional afull via WPTR_AFULL_EN.
module wptr_full #(
   parameter int ADDR_W       = 3,
   parameter int AFULL_THRESH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              winc,
   input  logic [ADDR_W:0]   wq2_rptr,
   output logic              wen,
   output logic [ADDR_W-1:0] waddr,
   output logic [ADDR_W:0]   wptr,
   output logic              wfull,
   output logic              afull,
   output logic              wovf
);

   localparam int DEPTH = 2 ** ADDR_W;

   if (ADDR_W < 2 || AFULL_THRESH < 1 || AFULL_THRESH > DEPTH - 1) begin : g_bad_cfg
      $error("wptr_full: illegal ADDR_W/AFULL_THRESH combination");
   end

   logic [ADDR_W:0] wbin;
   logic [ADDR_W:0] wbin_next;
   logic [ADDR_W:0] wgray_next;
   logic [ADDR_W:0] full_cmp;

   assign wen        = winc & ~wfull;
   assign waddr      = wbin[ADDR_W-1:0];
   assign wbin_next  = wbin + {{ADDR_W{1'b0}}, wen};
   assign wgray_next = (wbin_next >> 1) ^ wbin_next;

   // Full when the next write pointer is exactly one lap ahead of the read pointer.
   assign full_cmp = {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin  <= '0;
         wptr  <= '0;
         wfull <= 1'b0;
         wovf  <= 1'b0;
      end else begin
         wbin  <= wbin_next;
         wptr  <= wgray_next;
         wfull <= (wgray_next == full_cmp);
         if (winc && wfull) begin
            wovf <= 1'b1;
         end
      end
   end

`ifdef WPTR_AFULL_EN
   localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W + 1)'(DEPTH - AFULL_THRESH);

   logic [ADDR_W:0] rbin;
   logic [ADDR_W:0] fill_next;

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   for (genvar i = 0; i <= ADDR_W; i++) begin : g_g2b
      assign rbin[i] = ^wq2_rptr[ADDR_W:i];
   end

   assign fill_next = wbin_next - rbin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         afull <= 1'b0;
      end else begin
         afull <= (fill_next >= AFULL_LVL);
      end
   end
`else
   assign afull = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full.sv
// Randomized scoreboard bench for wptr_full; reference model tracks write/read counts as plain integers.
module tb_wptr_full;

   localparam int ADDR_W = 3;
   localparam int AFULL_THRESH = 2;
   localparam int DEPTH = 2 ** ADDR_W;
`ifdef WPTR_AFULL_EN
   localparam bit AFEN = 1'b1;
`else
   localparam bit AFEN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              winc;
   logic [ADDR_W:0]   wq2_rptr;
   logic              wen;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W:0]   wptr;
   logic              wfull;
   logic              afull;
   logic              wovf;

   wptr_full #(.ADDR_W(ADDR_W), .AFULL_THRESH(AFULL_THRESH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .winc     (winc),
      .wq2_rptr (wq2_rptr),
      .wen      (wen),
      .waddr    (waddr),
      .wptr     (wptr),
      .wfull    (wfull),
      .afull    (afull),
      .wovf     (wovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit              live;
      logic [ADDR_W:0] wptr;
      logic [ADDR_W-1:0] waddr;
      logic            wfull;
      logic            afull;
      logic            wovf;
   } st_t;

   logic wen_q[$];
   st_t  st_q[$];

   int errors = 0;
   int checks = 0;

   // model: total accepted writes and the read count currently presented
   int w = 0;
   bit m_full = 1'b0;
   bit m_afull = 1'b0;
   bit m_ovf = 1'b0;
   int hist[$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [ADDR_W:0] gray(input int x);
      logic [ADDR_W:0] b;
      b = (ADDR_W + 1)'(x % (2 * DEPTH));
      return b ^ (b >> 1);
   endfunction

   task automatic step(input bit rst, input bit inc, input int rcnt);
      bit wen_e;
      st_t s;
      @(posedge clk);
      #1;
      winc = inc;
      wq2_rptr = gray(rcnt);
      if (rst_n && !rst) begin
         // asynchronous assertion mid-cycle: outputs must clear without a clock edge
         #2;
         rst_n = 1'b0;
         #1;
         chk("async_rst_wptr", int'(wptr), 0);
         chk("async_rst_waddr", int'(waddr), 0);
         chk("async_rst_wfull", int'(wfull), 0);
         chk("async_rst_afull", int'(afull), 0);
         chk("async_rst_wovf", int'(wovf), 0);
      end else begin
         rst_n = rst;
      end
      if (!rst) begin
         w = 0;
         m_full = 1'b0;
         m_afull = 1'b0;
         m_ovf = 1'b0;
         wen_e = inc;
      end else begin
         wen_e = inc && !m_full;
         if (inc && m_full) m_ovf = 1'b1;
         if (wen_e) w++;
         m_full = ((w - rcnt) == DEPTH);
         m_afull = AFEN && ((w - rcnt) >= DEPTH - AFULL_THRESH);
      end
      s.live  = rst;
      s.wptr  = gray(w);
      s.waddr = ADDR_W'(w % DEPTH);
      s.wfull = m_full;
      s.afull = m_afull;
      s.wovf  = m_ovf;
      wen_q.push_back(wen_e);
      st_q.push_back(s);
   endtask

   // monitor: wen checked mid-cycle, registered state checked just after each edge
   initial begin
      logic e;
      st_t s;
      logic [ADDR_W:0] prev;
      bit have_prev;
      have_prev = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         #1;
         if (wen_q.size() > 0) begin
            e = wen_q.pop_front();
            chk("wen", int'(wen), int'(e));
         end
         @(posedge clk);
         #2;
         if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("wptr", int'(wptr), int'(s.wptr));
            chk("waddr", int'(waddr), int'(s.waddr));
            chk("wfull", int'(wfull), int'(s.wfull));
            chk("afull", int'(afull), int'(s.afull));
            chk("wovf", int'(wovf), int'(s.wovf));
            if (s.live && have_prev)
               chk("wptr_hamming_le1", int'($countones(wptr ^ prev) <= 1), 1);
            prev = wptr;
            have_prev = s.live;
         end
      end
   end

   initial begin
      int rc;
      int lag;
      rst_n = 1'b0;
      winc = 1'b1;
      wq2_rptr = '0;

      // held in reset with writes requested
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0);

      // fill to full, then overflow attempts
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 0);

      // one slot freed, then refilled
      step(1'b1, 1'b0, 1);
      step(1'b1, 1'b1, 1);
      step(1'b1, 1'b0, 1);

      // reset mid-operation, read side reset alongside
      step(1'b0, 1'b0, 0);
      step(1'b0, 1'b1, 0);
      hist.delete();

      // 32 writes with the read pointer following two cycles behind
      for (int i = 0; i < 32; i++) begin
         rc = (hist.size() >= 2) ? hist[hist.size() - 2] : 0;
         step(1'b1, 1'b1, rc);
         hist.push_back(w);
      end

      // random traffic; reader never passes the lagged write count
      rc = hist[hist.size() - 1];
      for (int i = 0; i < 400; i++) begin
         lag = hist[hist.size() - 2];
         if (rc < lag && $urandom_range(0, 2) == 0) rc++;
         if (i == 200) begin
            step(1'b0, 1'b1, 0);
            step(1'b0, 1'b0, 0);
            hist.delete();
            hist.push_back(0);
            hist.push_back(0);
            rc = 0;
         end else begin
            step(1'b1, $urandom_range(0, 3) != 0, rc);
            hist.push_back(w);
         end
      end
      step(1'b1, 1'b0, rc);

      repeat (3) @(posedge clk);
      #3;
      chk("drain_wen_q", wen_q.size(), 0);
      chk("drain_st_q", st_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wptr_full.md
WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001: Parameter ADDR_W, default 3: FIFO address width, giving DEPTH = 2**ADDR_W; the pointer is ADDR_W+1 bits and matches the synchronizer default width of 4; legal range ADDR_W >= 2.
REQ-002: Parameter AFULL_THRESH, default 2: free-slot count at or below which afull asserts; legal range 1..DEPTH-1.
REQ-003: clk  input  1  write-domain clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: winc  input  1  write request from the producer.
REQ-006: wq2_rptr  input  ADDR_W+1  Gray read pointer, already passed through the two-stage synchronizer into clk.
REQ-007: wen  output  1  RAM write strobe; combinational, winc AND NOT wfull.
REQ-008: waddr  output  ADDR_W  RAM write address; equals wbin[ADDR_W-1:0].
REQ-009: wptr  output  ADDR_W+1  registered Gray write pointer; drives the read-domain synchronizer input.
REQ-010: wfull  output  1  registered full flag.
REQ-011: afull  output  1  registered almost-full flag (see Configuration).
REQ-012: wovf  output  1  sticky overflow flag.

Function
REQ-013: Internal binary pointer wbin (ADDR_W+1 bits); wbin_next = wbin + wen, modulo 2**(ADDR_W+1).
REQ-014: wgray_next = (wbin_next >> 1) XOR wbin_next; wbin and wptr register wbin_next and wgray_next on every clk edge.
REQ-015: An accepted write advances waddr and wptr on the same edge that captures the data; latency from wen to wptr change is 1 clk.
REQ-016: wptr changes by exactly one bit per accepted write, including the wrap from all-ones binary to 0; it never changes without wen.
REQ-017: wfull is registered from (wgray_next == {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]}); it asserts on the edge of the write that fills slot DEPTH.
REQ-018: wfull deasserts on the first clk edge after wq2_rptr advances, provided no write refills the freed slot on that same edge.
REQ-019: A simultaneous write and wq2_rptr advance while full: the write is dropped (wen=0), and wfull is re-evaluated from the new wq2_rptr.
REQ-020: winc while wfull=1: pointer and address hold, and wovf sets on that edge and stays 1 until reset.
REQ-021: Every output is glitch-free registered state, except wen and waddr, which are combinational decodes of wbin and wfull.

Reset
REQ-022: On rst_n low, immediately and regardless of clk: wbin=0, wptr=0, wfull=0, afull=0, wovf=0; wen follows winc.
REQ-023: Reset mid-operation discards all in-flight pointer state; the read-side pointer shall be reset in the same assertion window.
REQ-024: Reset deassertion is synchronous to clk, provided externally; the first write is accepted on the first edge after release.

Configuration
REQ-025: Macro WPTR_AFULL_EN compiles in the almost-full logic.
REQ-026: With WPTR_AFULL_EN defined, the block converts wq2_rptr from Gray to binary rbin, and afull is registered as ((wbin_next - rbin) mod 2**(ADDR_W+1)) >= DEPTH - AFULL_THRESH.
REQ-027: Without WPTR_AFULL_EN, afull is tied to 0, no Gray-to-binary or subtractor logic is generated, and all other behaviour is identical.

Verification (ADDR_W=3, AFULL_THRESH=2, WPTR_AFULL_EN defined)
REQ-028: rst_n=0 with winc=1 and clk running -> wptr=0000, waddr=000, wfull=0, afull=0, wovf=0 throughout.
REQ-029: wq2_rptr=0000, winc=1 for 8 clk -> wptr sequence 0001,0011,0010,0110,0111,0101,0100,1100; wfull=1 after the 8th edge; afull=1 after the 6th edge.
REQ-030: From full, winc=1 for 3 further clk -> wen=0, wptr stays 1100, waddr stays 000, wovf=1 and remains 1.
REQ-031: From full, set wq2_rptr=0001 -> wfull=0 on the next edge; the following write lands at waddr=000 and wptr becomes 1101, wfull=1.
REQ-032: 32 writes with wq2_rptr tracking wptr two cycles late -> wptr wraps 1000 to 0000 twice, Hamming distance between consecutive wptr values is 1 or 0, and wfull never asserts.
REQ-033: Build without WPTR_AFULL_EN, repeat REQ-029 -> afull=0 throughout; all other values are identical.
